// File: rtl/clock_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_reset_sequencer                                        |
// | Description : Ordered reset release (memories, regfile, core), core clock  |
// |               enable divider and orderly halt/resume with frozen state.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module clock_reset_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_GAP   = 2,
    parameter int DIV         = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt,
    input  logic             resume,
    output logic             imem_rst,
    output logic             dmem_rst,
    output logic             regfile_rst,
    output logic             processor_rst,
    output logic             mem_en,
    output logic             processor_en,
    output logic             running,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] c_ST_RST     = 3'd0;
    localparam logic [2:0] c_ST_HOLD    = 3'd1;
    localparam logic [2:0] c_ST_REL_MEM = 3'd2;
    localparam logic [2:0] c_ST_REL_RF  = 3'd3;
    localparam logic [2:0] c_ST_RUN     = 3'd4;
    localparam logic [2:0] c_ST_DRAIN   = 3'd5;
    localparam logic [2:0] c_ST_HALTED  = 3'd6;

    // One shared timer serves HOLD and every STAGE_GAP-long stage.
    localparam int c_TMR_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam int c_DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [c_TMR_W-1:0] c_HOLD_LAST = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST  = c_TMR_W'(STAGE_GAP - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);

    logic [2:0]         r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_DIV_W-1:0] r_div;
    logic               r_imem_rst;
    logic               r_dmem_rst;
    logic               r_regfile_rst;
    logic               r_processor_rst;
    logic               r_mem_en;
    logic               r_processor_en;
    logic               r_running;
    logic               r_halted;
    logic [CNT_W-1:0]   r_count;

    logic [2:0]         w_state_nxt;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic               w_en_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_div_nxt   = r_div;
        case (r_state)
            c_ST_RST: begin
                w_state_nxt = c_ST_HOLD;
                w_timer_nxt = '0;
            end
            c_ST_HOLD: begin
                if (r_timer == c_HOLD_LAST) begin
                    w_state_nxt = c_ST_REL_MEM;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end
            c_ST_REL_MEM: begin
                if (r_timer == c_GAP_LAST) begin
                    w_state_nxt = c_ST_REL_RF;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end
            c_ST_REL_RF: begin
                if (r_timer == c_GAP_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_timer_nxt = '0;
                    w_div_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end
            c_ST_RUN: begin
                if (halt) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_timer_nxt = '0;
                end else if (r_div == c_DIV_LAST) begin
                    w_div_nxt = '0;
                end else begin
                    w_div_nxt = r_div + c_DIV_ONE;
                end
            end
            c_ST_DRAIN: begin
                if (r_timer == c_GAP_LAST) begin
                    w_state_nxt = c_ST_HALTED;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end
            c_ST_HALTED: begin
                // halt has priority, so a simultaneous resume is dropped
                if (resume && !halt) begin
                    w_state_nxt = c_ST_RUN;
                    w_div_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_RST;
                w_timer_nxt = '0;
                w_div_nxt   = '0;
            end
        endcase
    end

    assign w_en_nxt = (w_state_nxt == c_ST_RUN) && (w_div_nxt == c_DIV_LAST);

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= c_ST_RST;
            r_timer         <= '0;
            r_div           <= '0;
            r_imem_rst      <= 1'b1;
            r_dmem_rst      <= 1'b1;
            r_regfile_rst   <= 1'b1;
            r_processor_rst <= 1'b1;
            r_mem_en        <= 1'b0;
            r_processor_en  <= 1'b0;
            r_running       <= 1'b0;
            r_halted        <= 1'b0;
            r_count         <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_div           <= w_div_nxt;
            r_imem_rst      <= (w_state_nxt == c_ST_RST) || (w_state_nxt == c_ST_HOLD);
            r_dmem_rst      <= (w_state_nxt == c_ST_RST) || (w_state_nxt == c_ST_HOLD);
            r_regfile_rst   <= (w_state_nxt == c_ST_RST) || (w_state_nxt == c_ST_HOLD) ||
                               (w_state_nxt == c_ST_REL_MEM);
            r_processor_rst <= (w_state_nxt == c_ST_RST) || (w_state_nxt == c_ST_HOLD) ||
                               (w_state_nxt == c_ST_REL_MEM) || (w_state_nxt == c_ST_REL_RF);
            r_mem_en        <= (w_state_nxt == c_ST_REL_MEM) || (w_state_nxt == c_ST_REL_RF) ||
                               (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_DRAIN);
            r_processor_en  <= w_en_nxt;
            r_running       <= (w_state_nxt == c_ST_RUN);
            r_halted        <= (w_state_nxt == c_ST_HALTED);
            if (w_en_nxt && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    assign state         = r_state;
    assign imem_rst      = r_imem_rst;
    assign dmem_rst      = r_dmem_rst;
    assign regfile_rst   = r_regfile_rst;
    assign processor_rst = r_processor_rst;
    assign mem_en        = r_mem_en;
    assign processor_en  = r_processor_en;
    assign running       = r_running;
    assign halted        = r_halted;
    assign cycle_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_clock_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clock_reset_sequencer                                     |
// | Description : Scoreboard bench: directed stimulus queues expected values,  |
// |               a negedge monitor compares them against three DUT variants.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_clock_reset_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halt = 1'b0;
    logic resume = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance
    logic        a_imem, a_dmem, a_rf, a_proc, a_mem_en, a_en, a_run, a_halted;
    logic [2:0]  a_state;
    logic [31:0] a_count;
    // DIV=1 instance
    logic        b_imem, b_dmem, b_rf, b_proc, b_mem_en, b_en, b_run, b_halted;
    logic [2:0]  b_state;
    logic [31:0] b_count;
    // CNT_W=4 instance
    logic        c_imem, c_dmem, c_rf, c_proc, c_mem_en, c_en, c_run, c_halted;
    logic [2:0]  c_state;
    logic [3:0]  c_count;

    clock_reset_sequencer u_dut (
        .clock(clk), .reset(reset), .halt(halt), .resume(resume),
        .imem_rst(a_imem), .dmem_rst(a_dmem), .regfile_rst(a_rf), .processor_rst(a_proc),
        .mem_en(a_mem_en), .processor_en(a_en), .running(a_run), .halted(a_halted),
        .state(a_state), .cycle_count(a_count)
    );

    clock_reset_sequencer #(.DIV(1)) u_dut_div1 (
        .clock(clk), .reset(reset), .halt(halt), .resume(resume),
        .imem_rst(b_imem), .dmem_rst(b_dmem), .regfile_rst(b_rf), .processor_rst(b_proc),
        .mem_en(b_mem_en), .processor_en(b_en), .running(b_run), .halted(b_halted),
        .state(b_state), .cycle_count(b_count)
    );

    clock_reset_sequencer #(.CNT_W(4)) u_dut_cnt4 (
        .clock(clk), .reset(reset), .halt(halt), .resume(resume),
        .imem_rst(c_imem), .dmem_rst(c_dmem), .regfile_rst(c_rf), .processor_rst(c_proc),
        .mem_en(c_mem_en), .processor_en(c_en), .running(c_run), .halted(c_halted),
        .state(c_state), .cycle_count(c_count)
    );

    localparam int S_STATE = 0, S_RSTV = 1, S_MEMEN = 2, S_EN = 3, S_RUN = 4,
                   S_HALTED = 5, S_COUNT = 6, S_D1_EN = 7, S_D1_COUNT = 8, S_C4_COUNT = 9;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_STATE:    return {29'd0, a_state};
            S_RSTV:     return {28'd0, a_imem, a_dmem, a_rf, a_proc};
            S_MEMEN:    return {31'd0, a_mem_en};
            S_EN:       return {31'd0, a_en};
            S_RUN:      return {31'd0, a_run};
            S_HALTED:   return {31'd0, a_halted};
            S_COUNT:    return a_count;
            S_D1_EN:    return {31'd0, b_en};
            S_D1_COUNT: return b_count;
            S_C4_COUNT: return {28'd0, c_count};
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(input int at, input int sig, input logic [31:0] val, input string name);
        exp_t e;
        e.at = at; e.sig = sig; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int at);
        while (cyc < at) tick(1);
    endtask

    // Monitor: each cycle, retire every expectation scheduled for this cycle.
    always @(negedge clk) begin
        logic [31:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                got = sample(sb[i].sig);
                checks++;
                if (sb[i].at < cyc || got !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s @cyc%0d: got 0x%0h expected 0x%0h",
                             sb[i].name, sb[i].at, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int b, b2, b3;

        // Reset state
        tick(2);
        checks++;
        if (a_state !== 3'd0) begin
            failures++;
            $display("FAIL direct_reset_state: got %0d", a_state);
        end
        checks++;
        if ({a_imem, a_dmem, a_rf, a_proc} !== 4'b1111) begin
            failures++;
            $display("FAIL direct_reset_rsts: got %b", {a_imem, a_dmem, a_rf, a_proc});
        end
        checks++;
        if ({a_mem_en, a_en} !== 2'b00) begin
            failures++;
            $display("FAIL direct_reset_enables: got %b", {a_mem_en, a_en});
        end
        checks++;
        if (a_count !== 32'd0) begin
            failures++;
            $display("FAIL direct_reset_count: got %0d", a_count);
        end
        checks++;
        if (b_count !== 32'd0) begin
            failures++;
            $display("FAIL direct_reset_div1_count: got %0d", b_count);
        end
        checks++;
        if (c_count !== 4'd0) begin
            failures++;
            $display("FAIL direct_reset_cnt4_count: got %0d", c_count);
        end
        expect_at(cyc, S_STATE,    0,       "reset_state");
        expect_at(cyc, S_RSTV,     4'b1111, "reset_rsts");
        expect_at(cyc, S_MEMEN,    0,       "reset_mem_en");
        expect_at(cyc, S_EN,       0,       "reset_en");
        expect_at(cyc, S_COUNT,    0,       "reset_count");
        expect_at(cyc, S_RUN,      0,       "reset_running");
        expect_at(cyc, S_HALTED,   0,       "reset_halted");

        // Release sequence, E0 = b
        b = cyc + 1;
        expect_at(b + 0,  S_STATE, 1,       "e0_hold");
        expect_at(b + 3,  S_STATE, 1,       "e3_hold");
        expect_at(b + 3,  S_RSTV,  4'b1111, "e3_rsts");
        expect_at(b + 4,  S_STATE, 2,       "e4_rel_mem");
        expect_at(b + 4,  S_RSTV,  4'b0011, "e4_rsts");
        expect_at(b + 4,  S_MEMEN, 1,       "e4_mem_en");
        expect_at(b + 6,  S_STATE, 3,       "e6_rel_rf");
        expect_at(b + 6,  S_RSTV,  4'b0001, "e6_rsts");
        expect_at(b + 8,  S_STATE, 4,       "e8_run");
        expect_at(b + 8,  S_RSTV,  4'b0000, "e8_rsts");
        expect_at(b + 8,  S_RUN,   1,       "e8_running");
        expect_at(b + 8,  S_EN,    0,       "e8_en");
        expect_at(b + 8,  S_D1_EN, 1,       "e8_div1_en");
        expect_at(b + 9,  S_EN,    1,       "e9_first_pulse");
        expect_at(b + 9,  S_COUNT, 1,       "e9_count");
        expect_at(b + 10, S_EN,    0,       "e10_en");
        expect_at(b + 10, S_COUNT, 1,       "e10_count");
        expect_at(b + 19, S_D1_EN, 1,       "e19_div1_en");
        expect_at(b + 27, S_EN,    1,       "e27_pulse");
        expect_at(b + 27, S_COUNT, 10,      "e27_count");
        expect_at(b + 27, S_D1_COUNT, 20,   "e27_div1_count");
        expect_at(b + 27, S_C4_COUNT, 10,   "e27_cnt4_count");
        reset = 1'b0;

        // Halt in the pulse cycle
        tick_to(b + 27);
        halt = 1'b1;
        expect_at(b + 28, S_STATE, 5,       "drain_state");
        expect_at(b + 28, S_EN,    0,       "drain_en");
        expect_at(b + 28, S_MEMEN, 1,       "drain_mem_en");
        expect_at(b + 28, S_RSTV,  4'b0000, "drain_rsts");
        expect_at(b + 28, S_COUNT, 10,      "drain_count");
        expect_at(b + 28, S_RUN,   0,       "drain_running");
        expect_at(b + 29, S_STATE, 5,       "drain2_state");
        expect_at(b + 29, S_MEMEN, 1,       "drain2_mem_en");
        expect_at(b + 30, S_STATE, 6,       "halted_state");
        expect_at(b + 30, S_HALTED, 1,      "halted_flag");
        expect_at(b + 30, S_MEMEN, 0,       "halted_mem_en");
        expect_at(b + 30, S_RSTV,  4'b0000, "halted_rsts");
        expect_at(b + 33, S_COUNT, 10,      "halted_count_frozen");
        expect_at(b + 33, S_STATE, 6,       "halted_hold");
        tick(1);
        halt = 1'b0;

        // halt+resume together in HALTED, then resume alone
        tick_to(b + 33);
        halt = 1'b1;
        resume = 1'b1;
        expect_at(b + 34, S_STATE, 6,       "halt_wins");
        tick(1);
        halt = 1'b0;
        expect_at(b + 35, S_STATE, 4,       "resume_run");
        expect_at(b + 35, S_EN,    0,       "resume_en0");
        expect_at(b + 35, S_RUN,   1,       "resume_running");
        expect_at(b + 35, S_COUNT, 10,      "resume_count");
        expect_at(b + 36, S_EN,    1,       "resume_pulse");
        expect_at(b + 36, S_COUNT, 11,      "resume_count_inc");
        expect_at(b + 37, S_EN,    0,       "resume_en_low");
        tick(1);
        resume = 1'b0;

        // Reset mid-RUN
        tick_to(b + 40);
        reset = 1'b1;
        expect_at(b + 41, S_STATE, 0,       "midrun_rst_state");
        expect_at(b + 41, S_RSTV,  4'b1111, "midrun_rst_rsts");
        expect_at(b + 41, S_MEMEN, 0,       "midrun_rst_mem_en");
        expect_at(b + 41, S_EN,    0,       "midrun_rst_en");
        expect_at(b + 41, S_COUNT, 0,       "midrun_rst_count");
        expect_at(b + 41, S_D1_EN, 0,       "midrun_rst_div1_en");
        expect_at(b + 41, S_C4_COUNT, 0,    "midrun_rst_cnt4");
        tick(1);
        reset = 1'b0;
        b2 = cyc + 1;
        expect_at(b2 + 0, S_STATE, 1,       "rerun_hold");
        expect_at(b2 + 4, S_STATE, 2,       "rerun_rel_mem");
        expect_at(b2 + 6, S_STATE, 3,       "rerun_rel_rf");
        expect_at(b2 + 8, S_STATE, 4,       "rerun_run");
        expect_at(b2 + 9, S_EN,    1,       "rerun_pulse");
        expect_at(b2 + 9, S_COUNT, 1,       "rerun_count");

        // Reset mid-DRAIN
        tick_to(b2 + 9);
        halt = 1'b1;
        expect_at(b2 + 10, S_STATE, 5,      "drain_again");
        tick(1);
        halt = 1'b0;
        reset = 1'b1;
        expect_at(b2 + 11, S_STATE, 0,       "middrain_rst_state");
        expect_at(b2 + 11, S_RSTV,  4'b1111, "middrain_rst_rsts");
        expect_at(b2 + 11, S_MEMEN, 0,       "middrain_rst_mem_en");
        expect_at(b2 + 11, S_COUNT, 0,       "middrain_rst_count");
        tick(1);
        reset = 1'b0;

        // Long run: narrow counter saturates at 15
        b3 = cyc + 1;
        expect_at(b3 + 8,  S_STATE,    4,  "sat_run");
        expect_at(b3 + 36, S_C4_COUNT, 14, "cnt4_14");
        expect_at(b3 + 37, S_C4_COUNT, 15, "cnt4_15");
        expect_at(b3 + 39, S_C4_COUNT, 15, "cnt4_sat");
        expect_at(b3 + 49, S_C4_COUNT, 15, "cnt4_no_wrap");
        expect_at(b3 + 49, S_COUNT,    21, "wide_count");
        expect_at(b3 + 49, S_EN,       1,  "late_pulse");
        tick_to(b3 + 52);

        for (int i = 0; i < sb.size(); i++) begin
            checks++;
            failures++;
            $display("FAIL %s @cyc%0d: never checked, expected 0x%0h", sb[i].name, sb[i].at, sb[i].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
